// File: rtl/pair_atom_sched_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pair_atom_sched_if : requester and response handshake bundle for pair_atom_sched
// Revision 1.0
// ----------------------------------------------------------------------------
interface pair_atom_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_pkt1;
  logic [NUM_REQ*32-1:0] req_pkt2;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_old1;
  logic [31:0]           rsp_old2;
  logic [31:0]           rsp_new1;
  logic [31:0]           rsp_new2;

  modport slave (
    input  req_valid, req_pkt1, req_pkt2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_old1, rsp_old2, rsp_new1, rsp_new2
  );

  modport master (
    output req_valid, req_pkt1, req_pkt2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_old1, rsp_old2, rsp_new1, rsp_new2
  );
endinterface
`default_nettype wire

// File: rtl/pair_atom_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pair_atom_sched : round-robin issue, double-banked config and response path for one pair atom
// Revision 1.0
// ----------------------------------------------------------------------------
module pair_atom_sched #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  pair_atom_sched_if.slave  bus,
  input  logic              cfg_we,
  input  logic [5:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic              cfg_ready,
  input  logic              cfg_commit,
  output logic              cfg_err,
  output logic              atom_en,
  output logic [31:0]       atom_pkt1,
  output logic [31:0]       atom_pkt2,
  output logic [607:0]      atom_cons,
  output logic [65:0]       atom_sel,
  output logic [5:0]        atom_relop,
  input  logic [31:0]       atom_read1,
  input  logic [31:0]       atom_read2,
  input  logic [31:0]       atom_write1,
  input  logic [31:0]       atom_write2,
  output logic [31:0]       pkt_count
);

  localparam int           CONS_N   = 19;
  localparam int           SEL_N    = 33;
  localparam int           REL_N    = 3;
  localparam logic [5:0]   SEL_BASE = 6'd19;
  localparam logic [5:0]   REL_BASE = 6'd52;
  localparam logic [5:0]   ILL_BASE = 6'd55;
  localparam logic [ID_W:0] NREQ_W  = NUM_REQ[ID_W:0];

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_run;
  logic                w_swap;
  logic                w_cfg_wr;
  logic                w_issue;
  logic [ID_W-1:0]     w_winner;
  logic [ID_W:0]       w_idx;
  logic                w_found;
  logic [NUM_REQ-1:0]  w_ready;
  logic [31:0]         w_pkt1;
  logic [31:0]         w_pkt2;

  logic [ID_W-1:0]     r_rr_ptr;
  logic [607:0]        r_cons_sh;
  logic [607:0]        r_cons_ac;
  logic [65:0]         r_sel_sh;
  logic [65:0]         r_sel_ac;
  logic [5:0]          r_rel_sh;
  logic [5:0]          r_rel_ac;
  logic                r_cfg_err;
  logic [31:0]         r_last_pkt1;
  logic [31:0]         r_last_pkt2;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [31:0]         r_rsp_old1;
  logic [31:0]         r_rsp_old2;
  logic [31:0]         r_rsp_new1;
  logic [31:0]         r_rsp_new2;
  logic [31:0]         r_pkt_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // DRAIN gives the last issued atom update one cycle to land before the swap.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_run = 1'b1;
        if (cfg_commit) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_SWAP;
      end
      ST_SWAP: begin
        w_swap      = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign cfg_ready = w_run;
  assign w_cfg_wr  = cfg_we && w_run;
  assign cfg_err   = r_cfg_err;

  // Round-robin scan starting one past the last winner.
  always_comb begin
    w_idx    = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + k[ID_W:0];
      if (w_idx >= NREQ_W) begin
        w_idx = w_idx - NREQ_W;
      end
      if (!w_found && bus.req_valid[w_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_issue = rst_n && w_run && (!r_rsp_valid || bus.rsp_ready) && w_found;

  always_comb begin
    w_ready = '0;
    w_pkt1  = '0;
    w_pkt2  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == i[ID_W-1:0]) begin
        w_ready[i] = w_issue;
        w_pkt1     = bus.req_pkt1[32*i +: 32];
        w_pkt2     = bus.req_pkt2[32*i +: 32];
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign atom_en       = w_issue;
  assign atom_pkt1     = w_issue ? w_pkt1 : r_last_pkt1;
  assign atom_pkt2     = w_issue ? w_pkt2 : r_last_pkt2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cons_sh <= '0;
      r_cons_ac <= '0;
      r_sel_sh  <= '0;
      r_sel_ac  <= '0;
      r_rel_sh  <= '0;
      r_rel_ac  <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_wr && (cfg_addr >= ILL_BASE);
      if (w_cfg_wr) begin
        for (int k = 0; k < CONS_N; k++) begin
          if (cfg_addr == k[5:0]) begin
            r_cons_sh[32*k +: 32] <= cfg_wdata;
          end
        end
        for (int k = 0; k < SEL_N; k++) begin
          if (cfg_addr == SEL_BASE + k[5:0]) begin
            r_sel_sh[2*k +: 2] <= cfg_wdata[1:0];
          end
        end
        for (int k = 0; k < REL_N; k++) begin
          if (cfg_addr == REL_BASE + k[5:0]) begin
            r_rel_sh[2*k +: 2] <= cfg_wdata[1:0];
          end
        end
      end
      if (w_swap) begin
        r_cons_ac <= r_cons_sh;
        r_sel_ac  <= r_sel_sh;
        r_rel_ac  <= r_rel_sh;
      end
    end
  end

  assign atom_cons  = r_cons_ac;
  assign atom_sel   = r_sel_ac;
  assign atom_relop = r_rel_ac;

  // Response registers only move on issue, so they stay stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_last_pkt1 <= '0;
      r_last_pkt2 <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_old1  <= '0;
      r_rsp_old2  <= '0;
      r_rsp_new1  <= '0;
      r_rsp_new2  <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_issue) begin
        r_rr_ptr    <= w_winner;
        r_last_pkt1 <= w_pkt1;
        r_last_pkt2 <= w_pkt2;
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= w_winner;
        r_rsp_old1  <= atom_read1;
        r_rsp_old2  <= atom_read2;
        r_rsp_new1  <= atom_write1;
        r_rsp_new2  <= atom_write2;
        r_pkt_count <= r_pkt_count + 32'd1;
      end else if (bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_old1  = r_rsp_old1;
  assign bus.rsp_old2  = r_rsp_old2;
  assign bus.rsp_new1  = r_rsp_new1;
  assign bus.rsp_new2  = r_rsp_new2;
  assign pkt_count     = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_pair_atom_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pair_atom_sched : directed and randomized bench for pair_atom_sched against a behavioural model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_pair_atom_sched;
  localparam int NREQ = 2;
  localparam int IDW  = $clog2(NREQ);

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cfg_we, cfg_commit, cfg_ready, cfg_err, atom_en;
  logic [5:0]   cfg_addr;
  logic [31:0]  cfg_wdata, atom_pkt1, atom_pkt2, pkt_count;
  logic [607:0] atom_cons;
  logic [65:0]  atom_sel;
  logic [5:0]   atom_relop;
  logic [31:0]  atom_read1, atom_read2, atom_write1, atom_write2;

  pair_atom_sched_if #(.NUM_REQ(NREQ)) bus ();

  pair_atom_sched #(.NUM_REQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
    .cfg_commit(cfg_commit), .cfg_err(cfg_err), .atom_en(atom_en),
    .atom_pkt1(atom_pkt1), .atom_pkt2(atom_pkt2), .atom_cons(atom_cons),
    .atom_sel(atom_sel), .atom_relop(atom_relop),
    .atom_read1(atom_read1), .atom_read2(atom_read2),
    .atom_write1(atom_write1), .atom_write2(atom_write2), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: blocked counts non-RUN cycles left after a commit.
  int          m_rr, m_rid, m_win, m_block;
  bit          m_rv, m_err, m_issue;
  logic [31:0] m_o1, m_o2, m_n1, m_n2, m_cnt, m_lp1, m_lp2;
  logic [31:0] m_cons_sh [19];
  logic [31:0] m_cons_ac [19];
  logic [1:0]  m_sel_sh [33];
  logic [1:0]  m_sel_ac [33];
  logic [1:0]  m_rel_sh [3];
  logic [1:0]  m_rel_ac [3];

  function automatic void model_reset();
    m_rr = 0; m_rid = 0; m_win = 0; m_block = 0;
    m_rv = 0; m_err = 0; m_issue = 0;
    m_o1 = 0; m_o2 = 0; m_n1 = 0; m_n2 = 0; m_cnt = 0; m_lp1 = 0; m_lp2 = 0;
    for (int k = 0; k < 19; k++) begin m_cons_sh[k] = 0; m_cons_ac[k] = 0; end
    for (int k = 0; k < 33; k++) begin m_sel_sh[k] = 0; m_sel_ac[k] = 0; end
    for (int k = 0; k < 3; k++) begin m_rel_sh[k] = 0; m_rel_ac[k] = 0; end
  endfunction

  function automatic void model_comb();
    m_issue = 0;
    m_win   = 0;
    if (rst_n && m_block == 0 && (!m_rv || bus.rsp_ready)) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_rr + k) % NREQ;
        if (!m_issue && bus.req_valid[j]) begin
          m_issue = 1;
          m_win   = j;
        end
      end
    end
  endfunction

  function automatic void model_clock();
    int a;
    model_comb();
    a = int'(cfg_addr);
    m_err = cfg_we && m_block == 0 && a >= 55;
    if (m_issue) begin
      m_rv = 1; m_rid = m_win; m_rr = m_win;
      m_o1 = atom_read1; m_o2 = atom_read2; m_n1 = atom_write1; m_n2 = atom_write2;
      m_cnt = m_cnt + 1;
      m_lp1 = bus.req_pkt1[m_win*32 +: 32];
      m_lp2 = bus.req_pkt2[m_win*32 +: 32];
    end else if (bus.rsp_ready) begin
      m_rv = 0;
    end
    if (m_block == 0) begin
      if (cfg_we) begin
        if (a < 19) m_cons_sh[a] = cfg_wdata;
        else if (a < 52) m_sel_sh[a-19] = cfg_wdata[1:0];
        else if (a < 55) m_rel_sh[a-52] = cfg_wdata[1:0];
      end
      if (cfg_commit) m_block = 2;
    end else if (m_block == 2) begin
      m_block = 1;
    end else begin
      m_cons_ac = m_cons_sh;
      m_sel_ac  = m_sel_sh;
      m_rel_ac  = m_rel_sh;
      m_block   = 0;
    end
  endfunction

  function automatic logic [607:0] exp_cons();
    logic [607:0] v = '0;
    for (int k = 0; k < 19; k++) v[32*k +: 32] = m_cons_ac[k];
    return v;
  endfunction

  function automatic logic [65:0] exp_sel();
    logic [65:0] v = '0;
    for (int k = 0; k < 33; k++) v[2*k +: 2] = m_sel_ac[k];
    return v;
  endfunction

  function automatic logic [5:0] exp_rel();
    logic [5:0] v = '0;
    for (int k = 0; k < 3; k++) v[2*k +: 2] = m_rel_ac[k];
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    cfg_we = 0; cfg_commit = 0; cfg_addr = '0; cfg_wdata = '0;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    bus.req_valid = '1;
    #2;
    checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    checks++; if (atom_en !== 1'b0) begin errors++; $display("FAIL reset_atom_en: got %b want 0", atom_en); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt_count: got %h want 0", pkt_count); end
    checks++; if (atom_cons !== '0 || atom_sel !== '0 || atom_relop !== '0) begin errors++; $display("FAIL reset_banks: nonzero active bank"); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_config_load();
    idle_inputs();
    cfg_we = 1; cfg_addr = 6'd0;  cfg_wdata = 32'h10; tick();
    cfg_addr = 6'd26; cfg_wdata = 32'h2; tick();
    cfg_addr = 6'd52; cfg_wdata = 32'h3; cfg_commit = 1;
    #2;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_run: got %b want 1", cfg_ready); end
    tick();
    cfg_we = 0; cfg_commit = 0;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_blocked[%0d]: got %b want 0", c, cfg_ready); end
      checks++; if (atom_cons !== '0 || atom_sel !== '0 || atom_relop !== '0) begin errors++; $display("FAIL cfg_early_swap[%0d]: cons0 %h sel %h rel %h want 0", c, atom_cons[31:0], atom_sel, atom_relop); end
      tick();
    end
    #2;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_back: got %b want 1", cfg_ready); end
    checks++; if (atom_cons[31:0] !== 32'h10) begin errors++; $display("FAIL cfg_cons1: got %h want 10", atom_cons[31:0]); end
    checks++; if (atom_sel[15:14] !== 2'd2) begin errors++; $display("FAIL cfg_sel8: got %0d want 2", atom_sel[15:14]); end
    checks++; if (atom_relop[1:0] !== 2'd3) begin errors++; $display("FAIL cfg_relop1: got %0d want 3", atom_relop[1:0]); end
    checks++; if (atom_cons !== exp_cons() || atom_sel !== exp_sel() || atom_relop !== exp_rel()) begin errors++; $display("FAIL cfg_full_bank: sel got %h want %h", atom_sel, exp_sel()); end
  endtask

  task automatic test_round_robin();
    int          g [4] = '{1, 0, 1, 0};
    logic [31:0] p1 [2];
    logic [NREQ-1:0] er;
    idle_inputs();
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      p1[0] = $urandom; p1[1] = $urandom;
      bus.req_pkt1 = {p1[1], p1[0]};
      bus.req_pkt2 = {$urandom, $urandom};
      er = '0; er[g[i]] = 1'b1;
      #2;
      checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, bus.req_ready, er); end
      checks++; if (atom_en !== 1'b1 || atom_pkt1 !== p1[g[i]]) begin errors++; $display("FAIL rr_pkt[%0d]: en %b pkt %h want 1 %h", i, atom_en, atom_pkt1, p1[g[i]]); end
      if (i > 0) begin
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(g[i-1])) begin errors++; $display("FAIL rr_rsp_id[%0d]: valid %b id %0d want 1 %0d", i, bus.rsp_valid, bus.rsp_id, g[i-1]); end
      end
      tick();
    end
    bus.req_valid = '0;
    #2;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(0)) begin errors++; $display("FAIL rr_last_rsp: valid %b id %0d want 1 0", bus.rsp_valid, bus.rsp_id); end
    checks++; if (pkt_count !== 32'd4) begin errors++; $display("FAIL rr_pkt_count: got %0d want 4", pkt_count); end
    tick();
    #2;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_rsp_clear: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_response_data();
    logic [31:0] r2, w2;
    idle_inputs();
    r2 = $urandom; w2 = $urandom;
    bus.req_valid = 2'b01;
    atom_read1 = 32'd5; atom_write1 = 32'd9; atom_read2 = r2; atom_write2 = w2;
    tick();
    bus.req_valid = '0;
    atom_read1 = $urandom; atom_write1 = $urandom;
    #2;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(0)) begin errors++; $display("FAIL rsp_valid_id: valid %b id %0d want 1 0", bus.rsp_valid, bus.rsp_id); end
    checks++; if (bus.rsp_old1 !== 32'd5 || bus.rsp_new1 !== 32'd9) begin errors++; $display("FAIL rsp_data1: old %0d new %0d want 5 9", bus.rsp_old1, bus.rsp_new1); end
    checks++; if (bus.rsp_old2 !== r2 || bus.rsp_new2 !== w2) begin errors++; $display("FAIL rsp_data2: old %h new %h want %h %h", bus.rsp_old2, bus.rsp_new2, r2, w2); end
    tick();
  endtask

  task automatic test_backpressure();
    int          sid;
    logic [31:0] so1, sn1, sp1;
    logic [NREQ-1:0] er;
    idle_inputs();
    bus.req_valid = 2'b11;
    bus.req_pkt1 = {$urandom, $urandom};
    atom_read1 = $urandom; atom_write1 = $urandom;
    tick();
    sid = m_rid; so1 = m_o1; sn1 = m_n1; sp1 = m_lp1;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.req_pkt1 = {$urandom, $urandom};
      atom_read1 = $urandom; atom_write1 = $urandom;
      #2;
      checks++; if (bus.req_ready !== '0 || atom_en !== 1'b0) begin errors++; $display("FAIL bp_blocked[%0d]: ready %b en %b want 0 0", c, bus.req_ready, atom_en); end
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(sid) || bus.rsp_old1 !== so1 || bus.rsp_new1 !== sn1) begin errors++; $display("FAIL bp_hold[%0d]: id %0d old %h new %h want %0d %h %h", c, bus.rsp_id, bus.rsp_old1, bus.rsp_new1, sid, so1, sn1); end
      checks++; if (atom_pkt1 !== sp1) begin errors++; $display("FAIL bp_pkt_hold[%0d]: got %h want %h", c, atom_pkt1, sp1); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #2;
    model_comb();
    er = '0; er[m_win] = 1'b1;
    checks++; if (atom_en !== 1'b1 || bus.req_ready !== er) begin errors++; $display("FAIL bp_resume: en %b ready %b want 1 %b", atom_en, bus.req_ready, er); end
    tick();
  endtask

  task automatic test_illegal_cfg();
    logic [31:0] x;
    idle_inputs();
    cfg_we = 1; cfg_addr = 6'd60; cfg_wdata = $urandom;
    tick();
    cfg_we = 0;
    #2;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_err_pulse: got %b want 1", cfg_err); end
    tick();
    #2;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_err_clear: got %b want 0", cfg_err); end
    checks++; if (atom_cons !== exp_cons() || atom_sel !== exp_sel() || atom_relop !== exp_rel()) begin errors++; $display("FAIL illegal_bank_change: active bank differs"); end
    x = $urandom;
    cfg_we = 1; cfg_addr = 6'd1; cfg_wdata = x; tick();
    cfg_we = 0; cfg_commit = 1; tick();
    cfg_commit = 0;
    cfg_we = 1; cfg_wdata = ~x; bus.req_valid = 2'b11;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++; if (cfg_ready !== 1'b0 || bus.req_ready !== '0 || atom_en !== 1'b0) begin errors++; $display("FAIL blocked_issue[%0d]: cfg_ready %b ready %b en %b want 0 0 0", c, cfg_ready, bus.req_ready, atom_en); end
      tick();
    end
    cfg_we = 0;
    #2;
    checks++; if (atom_cons[63:32] !== x) begin errors++; $display("FAIL swap_cons2: got %h want %h", atom_cons[63:32], x); end
    checks++; if (atom_en !== 1'b1) begin errors++; $display("FAIL first_run_issue: got %b want 1", atom_en); end
    tick();
    bus.req_valid = '0; cfg_commit = 1; tick();
    cfg_commit = 0; tick(); tick();
    #2;
    checks++; if (atom_cons[63:32] !== x) begin errors++; $display("FAIL drain_write_ignored: got %h want %h", atom_cons[63:32], x); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] er;
    logic [31:0]     ep1, ep2;
    for (int n = 0; n < 400; n++) begin
      bus.req_valid = NREQ'($urandom);
      bus.req_pkt1  = {$urandom, $urandom};
      bus.req_pkt2  = {$urandom, $urandom};
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      atom_read1 = $urandom; atom_read2 = $urandom; atom_write1 = $urandom; atom_write2 = $urandom;
      cfg_we     = ($urandom_range(0, 5) == 0);
      cfg_addr   = 6'($urandom_range(0, 63));
      cfg_wdata  = $urandom;
      cfg_commit = ($urandom_range(0, 19) == 0);
      #2;
      model_comb();
      er = '0;
      if (m_issue) er[m_win] = 1'b1;
      ep1 = m_issue ? bus.req_pkt1[m_win*32 +: 32] : m_lp1;
      ep2 = m_issue ? bus.req_pkt2[m_win*32 +: 32] : m_lp2;
      checks++; if (bus.req_ready !== er || atom_en !== m_issue) begin errors++; $display("FAIL rnd_grant[%0d]: ready %b en %b want %b %b", n, bus.req_ready, atom_en, er, m_issue); end
      checks++; if (atom_pkt1 !== ep1 || atom_pkt2 !== ep2) begin errors++; $display("FAIL rnd_pkt[%0d]: got %h %h want %h %h", n, atom_pkt1, atom_pkt2, ep1, ep2); end
      checks++; if (cfg_ready !== (m_block == 0)) begin errors++; $display("FAIL rnd_cfg_ready[%0d]: got %b want %b", n, cfg_ready, m_block == 0); end
      checks++; if (cfg_err !== m_err) begin errors++; $display("FAIL rnd_cfg_err[%0d]: got %b want %b", n, cfg_err, m_err); end
      checks++; if (bus.rsp_valid !== m_rv || bus.rsp_id !== IDW'(m_rid)) begin errors++; $display("FAIL rnd_rsp[%0d]: valid %b id %0d want %b %0d", n, bus.rsp_valid, bus.rsp_id, m_rv, m_rid); end
      checks++; if (bus.rsp_old1 !== m_o1 || bus.rsp_old2 !== m_o2 || bus.rsp_new1 !== m_n1 || bus.rsp_new2 !== m_n2) begin errors++; $display("FAIL rnd_rsp_data[%0d]: old1 %h new1 %h want %h %h", n, bus.rsp_old1, bus.rsp_new1, m_o1, m_n1); end
      checks++; if (pkt_count !== m_cnt) begin errors++; $display("FAIL rnd_pkt_count[%0d]: got %0d want %0d", n, pkt_count, m_cnt); end
      checks++; if (atom_cons !== exp_cons() || atom_sel !== exp_sel() || atom_relop !== exp_rel()) begin errors++; $display("FAIL rnd_bank[%0d]: sel %h rel %h want %h %h", n, atom_sel, atom_relop, exp_sel(), exp_rel()); end
      tick();
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_drain();
    idle_inputs();
    bus.req_valid = 2'b01;
    cfg_we = 1; cfg_addr = 6'd0; cfg_wdata = 32'hABCD; cfg_commit = 1;
    tick();
    cfg_we = 0; cfg_commit = 0; bus.req_valid = 2'b11;
    #2;
    checks++; if (bus.rsp_valid !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_pre: rsp_valid %b cfg_ready %b want 1 0", bus.rsp_valid, cfg_ready); end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_old1 !== '0 || pkt_count !== '0) begin errors++; $display("FAIL mid_rsp_clear: valid %b id %0d cnt %0d want 0", bus.rsp_valid, bus.rsp_id, pkt_count); end
    checks++; if (bus.req_ready !== '0 || atom_en !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_outputs: ready %b en %b cfg_ready %b want 0 0 1", bus.req_ready, atom_en, cfg_ready); end
    checks++; if (atom_cons !== '0 || atom_sel !== '0 || atom_relop !== '0) begin errors++; $display("FAIL mid_banks: nonzero active bank"); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.req_valid = 2'b11;
    #2;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL mid_first_grant: got %b want 10", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #2;
    checks++; if (bus.rsp_id !== IDW'(1) || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_rsp_id: id %0d valid %b want 1 1", bus.rsp_id, bus.rsp_valid); end
    tick(); tick();
    #2;
    checks++; if (atom_cons !== '0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_commit_discard: cons0 %h cfg_ready %b want 0 1", atom_cons[31:0], cfg_ready); end
  endtask

  initial begin
    idle_inputs();
    bus.req_pkt1 = '0; bus.req_pkt2 = '0;
    atom_read1 = '0; atom_read2 = '0; atom_write1 = '0; atom_write2 = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_config_load();
    test_round_robin();
    test_response_data();
    test_backpressure();
    test_illegal_cfg();
    test_random();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
